// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter for one shared combinational ALU, with a one-entry result buffer per requester.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties instead of alternating.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [3:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,

  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [3:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,

  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_result,

  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_result,

  output logic [3:0]       o_alu_control,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_result
);

  logic [1:0] w_req_valid;
  logic [1:0] w_rsp_ready;
  logic [1:0] w_free;
  logic [1:0] w_elig;
  logic [1:0] w_grant_raw;
  logic [1:0] w_grant;
  logic       r_last_grant;

  assign w_req_valid = {i_req1_valid, i_req0_valid};
  assign w_rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // A slot is free when empty or being drained on this same edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    assign w_free[gi] = !r_valid || w_rsp_ready[gi];
    assign w_elig[gi] = w_req_valid[gi] && w_free[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid  <= 1'b0;
        r_result <= '0;
      end else if (w_grant[gi]) begin
        r_valid  <= 1'b1;
        r_result <= i_alu_result;
      end else if (w_rsp_ready[gi]) begin
        r_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant_raw[0] = w_elig[0];
  assign w_grant_raw[1] = w_elig[1] && !w_elig[0];
`else
  // On a tie, the requester that did not win last time is served.
  assign w_grant_raw[0] = w_elig[0] && (!w_elig[1] || r_last_grant);
  assign w_grant_raw[1] = w_elig[1] && (!w_elig[0] || !r_last_grant);
`endif

  assign w_grant = w_grant_raw & {2{!rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grant[0]) begin
      r_last_grant <= 1'b0;
    end else if (w_grant[1]) begin
      r_last_grant <= 1'b1;
    end
  end

  always_comb begin
    o_alu_control = 4'b0000;
    o_alu_a       = '0;
    o_alu_b       = '0;
    if (w_grant[0]) begin
      o_alu_control = i_req0_op;
      o_alu_a       = i_req0_a;
      o_alu_b       = i_req0_b;
    end else if (w_grant[1]) begin
      o_alu_control = i_req1_op;
      o_alu_a       = i_req1_a;
      o_alu_b       = i_req1_b;
    end
  end

  assign o_req0_ready  = w_grant[0];
  assign o_req1_ready  = w_grant[1];
  assign o_rsp0_valid  = g_slot[0].r_valid;
  assign o_rsp1_valid  = g_slot[1].r_valid;
  assign o_rsp0_result = g_slot[0].r_result;
  assign o_rsp1_result = g_slot[1].r_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: an issue process predicts grants and pushes expected results,
// a separate monitor pops them as the DUT drains its response buffers.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int SH = $clog2(W);

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req0_valid, i_req1_valid;
  logic         o_req0_ready, o_req1_ready;
  logic [3:0]   i_req0_op, i_req1_op;
  logic [W-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic         o_rsp0_valid, o_rsp1_valid;
  logic         i_rsp0_ready, i_rsp1_ready;
  logic [W-1:0] o_rsp0_result, o_rsp1_result;
  logic [3:0]   o_alu_control;
  logic [W-1:0] o_alu_a, o_alu_b, i_alu_result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last_val0, last_val1;
  int           last_w;
  logic         acc0, acc1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready), .o_rsp0_result(o_rsp0_result),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready), .o_rsp1_result(o_rsp1_result),
    .o_alu_control(o_alu_control), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_result(i_alu_result)
  );

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd6: r = (a < b) ? W'(1) : W'(0);
      4'd7: r = a << b[SH-1:0];
      4'd8: r = a >> b[SH-1:0];
      4'd9: r = $signed(a) >>> b[SH-1:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  // The shared ALU lives outside the arbiter.
  assign i_alu_result = alu_fn(o_alu_control, o_alu_a, o_alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue side: predict the grant from the arbitration rules and queue the expected result.
  always begin
    logic e0, e1, g0, g1;
    @(posedge clk);
    #6;
    if (rst) begin
      chk("req0_ready_in_reset", o_req0_ready, 0);
      chk("req1_ready_in_reset", o_req1_ready, 0);
      q0.delete();
      q1.delete();
      last_w = 1;
    end else begin
      e0 = i_req0_valid && (q0.size() == 0);
      e1 = i_req1_valid && (q1.size() == 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
      g0 = e0;
      g1 = e1 && !e0;
`else
      if (e0 && e1) begin
        g0 = (last_w == 1);
        g1 = !g0;
      end else begin
        g0 = e0;
        g1 = e1;
      end
`endif
      chk("req0_ready", o_req0_ready, g0);
      chk("req1_ready", o_req1_ready, g1);
      if (g0) begin
        chk("alu_control", o_alu_control, i_req0_op);
        chk("alu_a", o_alu_a, i_req0_a);
        chk("alu_b", o_alu_b, i_req0_b);
        q0.push_back(alu_fn(i_req0_op, i_req0_a, i_req0_b));
        last_w = 0;
      end else if (g1) begin
        chk("alu_control", o_alu_control, i_req1_op);
        chk("alu_a", o_alu_a, i_req1_a);
        chk("alu_b", o_alu_b, i_req1_b);
        q1.push_back(alu_fn(i_req1_op, i_req1_a, i_req1_b));
        last_w = 1;
      end else begin
        chk("alu_control_idle", o_alu_control, 0);
        chk("alu_a_idle", o_alu_a, 0);
        chk("alu_b_idle", o_alu_b, 0);
      end
    end
  end

  // Response side: buffered results must match the queue head and hold after draining.
  always begin
    logic [W-1:0] e;
    @(posedge clk);
    #3;
    if (rst) begin
      chk("rsp0_valid_in_reset", o_rsp0_valid, 0);
      chk("rsp1_valid_in_reset", o_rsp1_valid, 0);
      chk("rsp0_result_in_reset", o_rsp0_result, 0);
      chk("rsp1_result_in_reset", o_rsp1_result, 0);
      last_val0 = '0;
      last_val1 = '0;
    end else begin
      chk("rsp0_valid", o_rsp0_valid, q0.size() != 0);
      if (q0.size() != 0) begin
        e = q0[0];
        chk("rsp0_result", o_rsp0_result, e);
        if (i_rsp0_ready) begin
          void'(q0.pop_front());
          last_val0 = e;
          $display("rsp0 taken result=%h expected=%h", o_rsp0_result, e);
        end
      end else begin
        chk("rsp0_result_hold", o_rsp0_result, last_val0);
      end
      chk("rsp1_valid", o_rsp1_valid, q1.size() != 0);
      if (q1.size() != 0) begin
        e = q1[0];
        chk("rsp1_result", o_rsp1_result, e);
        if (i_rsp1_ready) begin
          void'(q1.pop_front());
          last_val1 = e;
          $display("rsp1 taken result=%h expected=%h", o_rsp1_result, e);
        end
      end else begin
        chk("rsp1_result_hold", o_rsp1_result, last_val1);
      end
    end
  end

  // Advance from just after one rising edge to just after the next, noting handshakes on that edge.
  task automatic tick();
    #7;
    acc0 = i_req0_valid && o_req0_ready;
    acc1 = i_req1_valid && o_req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      i_req0_valid = v; i_req0_op = op; i_req0_a = a; i_req0_b = b;
    end else begin
      i_req1_valid = v; i_req1_op = op; i_req1_a = a; i_req1_b = b;
    end
  endtask

  task automatic rand_req(input int n);
    logic [W-1:0] b;
    b = ($urandom_range(1) != 0) ? W'($urandom) : W'($urandom_range(40));
    set_req(n, $urandom_range(3) != 0, 4'($urandom_range(9)), W'($urandom), b);
  endtask

  task automatic hit_reset();
    rst = 1'b1;
    #1;
    chk("rsp0_valid_async_clear", o_rsp0_valid, 0);
    chk("rsp1_valid_async_clear", o_rsp1_valid, 0);
    chk("rsp0_result_async_clear", o_rsp0_result, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    set_req(1, 1'b1, 4'd2, 32'hFF, 32'h0F);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    // Both requesting straight out of reset: requester 0 wins the first tie.
    rst = 1'b0;
    tick();
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);
    tick();

    // Single ADD 5 + 7.
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    tick();
    tick();

    // Contention: SUB 10-3 against SRA 0x80000000>>>4.
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd3);
    set_req(1, 1'b1, 4'd9, 32'h8000_0000, 32'd4);
    repeat (4) tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);
    tick();
    tick();

    // Backpressure on slot 1 while requester 0 keeps flowing.
    i_rsp1_ready = 1'b0;
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd2);
    tick();
    set_req(1, 1'b1, 4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    set_req(0, 1'b1, 4'd3, 32'h1234_0000, 32'h0000_5678);
    repeat (4) tick();
    i_rsp1_ready = 1'b1;
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);
    tick();
    tick();

    // Idle.
    repeat (3) tick();

    // Reset with a result sitting in slot 0.
    i_rsp0_ready = 1'b0;
    set_req(0, 1'b1, 4'd2, 32'hF0F0_1234, 32'hFFFF_0000);
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    tick();
    hit_reset();
    i_rsp0_ready = 1'b1;
    tick();

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 800; c++) begin
      if (!i_req0_valid || acc0) rand_req(0);
      if (!i_req1_valid || acc1) rand_req(1);
      i_rsp0_ready = ($urandom_range(9) < 7);
      i_rsp1_ready = ($urandom_range(9) < 7);
      if (c == 400) hit_reset();
      else tick();
    end

    // Drain everything still buffered.
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    repeat (4) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
